// File: rtl/wb_write_arbiter_pkg.sv
// Shared types and helpers for the write-back arbiter.
package wb_write_arbiter_pkg;

  // Starvation tracker states for a refused long-latency result.
  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_WAIT  = 2'd1,
    WB_DRAIN = 2'd2
  } wb_state_e;

  // Width of a counter that can hold 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/wb_write_arbiter_starve_ctr.sv
// Saturating starvation counter and 3-state FSM; requests a pipeline stall
// once a valid long-latency result has been refused STARVE_MAX times.
module wb_starve_ctr
  import wb_write_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      refuse,
  input  logic      accept,
  input  logic      valid,
  output logic      stallreq,
  output wb_state_e state
);

  localparam int CNT_W = cnt_width(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt;

  // FSM with registered stall request; neither refuse nor accept (flush) holds everything.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= WB_IDLE;
      cnt      <= '0;
      stallreq <= 1'b0;
    end else begin
      case (state)
        WB_IDLE: begin
          if (refuse) begin
            cnt <= CNT_ONE;
            if (CNT_ONE >= CNT_MAX) begin
              state    <= WB_DRAIN;
              stallreq <= 1'b1;
            end else begin
              state <= WB_WAIT;
            end
          end
        end
        WB_WAIT: begin
          if (accept || !valid) begin
            state <= WB_IDLE;
            cnt   <= '0;
          end else if (refuse) begin
            cnt <= cnt + CNT_ONE;
            if (cnt >= CNT_MAX - CNT_ONE) begin
              state    <= WB_DRAIN;
              stallreq <= 1'b1;
            end
          end
        end
        WB_DRAIN: begin
          // Counter is already saturated here; further refusals leave it at STARVE_MAX.
          if (accept || !valid) begin
            state    <= WB_IDLE;
            cnt      <= '0;
            stallreq <= 1'b0;
          end
        end
        default: begin
          state    <= WB_IDLE;
          cnt      <= '0;
          stallreq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Write-back stage register: merges the in-order MEM result and a
// long-latency handshake result onto the single regfile write port.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              lu_valid,
  input  logic [ADDR_W-1:0] lu_waddr,
  input  logic [DATA_W-1:0] lu_wdata,
  output logic              lu_ready,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              stallreq
);

  logic              mem_live;
  logic              lu_refuse;
  logic              lu_accept;
  logic              nxt_we;
  logic [ADDR_W-1:0] nxt_waddr;
  logic [DATA_W-1:0] nxt_wdata;
  wb_state_e         starve_state;

  // $0 writes, stalled and flushed slots never compete for the port.
  assign mem_live = mem_we && (mem_waddr != '0) && !stall_i && !flush_i;

  // Arbitration: flush, then MEM (stale LU on same address is retired), then LU fills the bubble.
  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    nxt_we    = 1'b0;
    nxt_waddr = '0;
    nxt_wdata = '0;
    lu_ready  = 1'b0;
    lu_refuse = 1'b0;
    lu_accept = 1'b0;
    if (rst || flush_i) begin
      // slot discarded, LU waits, counter holds
    end else if (mem_live) begin
      nxt_we    = 1'b1;
      nxt_waddr = mem_waddr;
      nxt_wdata = mem_wdata;
      if (lu_valid) begin
        if (lu_waddr == mem_waddr) begin
          lu_ready  = 1'b1;
          lu_accept = 1'b1;
        end else begin
          lu_refuse = 1'b1;
        end
      end
    end else if (lu_valid) begin
      lu_ready  = 1'b1;
      lu_accept = 1'b1;
      if (lu_waddr != '0) begin
        nxt_we    = 1'b1;
        nxt_waddr = lu_waddr;
        nxt_wdata = lu_wdata;
      end
    end
  end

  // Registered regfile write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we    <= 1'b0;
      wb_waddr <= '0;
      wb_wdata <= '0;
    end else begin
      wb_we    <= nxt_we;
      wb_waddr <= nxt_waddr;
      wb_wdata <= nxt_wdata;
    end
  end

  wb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_ctr (
    .clk     (clk),
    .rst     (rst),
    .refuse  (lu_refuse),
    .accept  (lu_accept),
    .valid   (lu_valid),
    .stallreq(stallreq),
    .state   (starve_state)
  );

  // Stall request is asserted exactly while the tracker sits in DRAIN.
  assert property (@(posedge clk) disable iff (rst) stallreq == (starve_state == WB_DRAIN));

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: pass-through, bubble fill, starvation,
// same-address retire, flush in DRAIN and asynchronous reset.
module tb_wb_write_arbiter;
  import wb_write_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        lu_valid;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        lu_ready;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        stallreq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_write_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_MAX(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .stall_i  (stall_i),
    .flush_i  (flush_i),
    .mem_we   (mem_we),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata),
    .lu_valid (lu_valid),
    .lu_waddr (lu_waddr),
    .lu_wdata (lu_wdata),
    .lu_ready (lu_ready),
    .wb_we    (wb_we),
    .wb_waddr (wb_waddr),
    .wb_wdata (wb_wdata),
    .stallreq (stallreq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic we, input logic [4:0] a, input logic [31:0] d);
    mem_we = we; mem_waddr = a; mem_wdata = d;
  endtask

  task automatic set_lu(input logic v, input logic [4:0] a, input logic [31:0] d);
    lu_valid = v; lu_waddr = a; lu_wdata = d;
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    set_mem(1'b0, 5'd0, 32'h0);
    set_lu(1'b0, 5'd0, 32'h0);
    #12;
    check("rst_wb_we", 32'(wb_we), 32'd0);
    check("rst_wb_waddr", 32'(wb_waddr), 32'd0);
    check("rst_wb_wdata", wb_wdata, 32'd0);
    check("rst_stallreq", 32'(stallreq), 32'd0);
    check("rst_lu_ready", 32'(lu_ready), 32'd0);
    #1 rst = 1'b0;
    tick();

    // MEM pass-through, then a $0 write that must be dropped
    set_mem(1'b1, 5'd5, 32'h1234_5678);
    #2 check("mem_lu_ready", 32'(lu_ready), 32'd0);
    tick();
    check("mem_we", 32'(wb_we), 32'd1);
    check("mem_waddr", 32'(wb_waddr), 32'd5);
    check("mem_wdata", wb_wdata, 32'h1234_5678);
    mem_waddr = 5'd0;
    tick();
    check("mem_r0_we", 32'(wb_we), 32'd0);

    // MEM stalled: slot is a bubble
    set_mem(1'b1, 5'd6, 32'h66);
    stall_i = 1'b1;
    tick();
    check("stall_bubble_we", 32'(wb_we), 32'd0);
    stall_i = 1'b0;

    // LU fills a bubble
    set_mem(1'b0, 5'd0, 32'h0);
    set_lu(1'b1, 5'd9, 32'hDEAD_BEEF);
    #2 check("fill_lu_ready", 32'(lu_ready), 32'd1);
    tick();
    check("fill_we", 32'(wb_we), 32'd1);
    check("fill_waddr", 32'(wb_waddr), 32'd9);
    check("fill_wdata", wb_wdata, 32'hDEAD_BEEF);

    // LU result to $0 is accepted but not written
    set_lu(1'b1, 5'd0, 32'h55);
    #2 check("lu_r0_ready", 32'(lu_ready), 32'd1);
    tick();
    check("lu_r0_we", 32'(wb_we), 32'd0);
    check("lu_r0_wdata", wb_wdata, 32'd0);

    // Two refusals then LU withdraws: back to IDLE, counter cleared
    set_mem(1'b1, 5'd3, 32'h33);
    set_lu(1'b1, 5'd7, 32'h77);
    tick();
    tick();
    check("wait_state", 32'(dut.u_ctr.state), 32'(WB_WAIT));
    check("wait_cnt", 32'(dut.u_ctr.cnt), 32'd2);
    lu_valid = 1'b0;
    tick();
    check("drop_state", 32'(dut.u_ctr.state), 32'(WB_IDLE));
    check("drop_cnt", 32'(dut.u_ctr.cnt), 32'd0);

    // Starvation: four refusals, then stallreq
    lu_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("starve_lu_ready", 32'(lu_ready), 32'd0);
      check("starve_stallreq", 32'(stallreq), 32'd0);
      tick();
      check("starve_wb_waddr", 32'(wb_waddr), 32'd3);
    end
    check("drain_stallreq", 32'(stallreq), 32'd1);
    check("drain_cnt", 32'(dut.u_ctr.cnt), 32'd4);

    // Flush during DRAIN: slot dropped, stallreq and counter hold
    flush_i = 1'b1;
    #2 check("flush_lu_ready", 32'(lu_ready), 32'd0);
    tick();
    check("flush_we", 32'(wb_we), 32'd0);
    check("flush_stallreq", 32'(stallreq), 32'd1);
    check("flush_cnt", 32'(dut.u_ctr.cnt), 32'd4);
    flush_i = 1'b0;

    // Controller answers with stall_i: LU granted, DRAIN released
    stall_i = 1'b1;
    #2 check("grant_lu_ready", 32'(lu_ready), 32'd1);
    tick();
    check("grant_we", 32'(wb_we), 32'd1);
    check("grant_waddr", 32'(wb_waddr), 32'd7);
    check("grant_wdata", wb_wdata, 32'h77);
    check("grant_stallreq", 32'(stallreq), 32'd0);
    check("grant_cnt", 32'(dut.u_ctr.cnt), 32'd0);
    stall_i = 1'b0;

    // Same-address conflict: MEM wins, stale LU retired without a write
    set_mem(1'b1, 5'd4, 32'h1);
    set_lu(1'b1, 5'd4, 32'h2);
    #2 check("same_lu_ready", 32'(lu_ready), 32'd1);
    tick();
    check("same_waddr", 32'(wb_waddr), 32'd4);
    check("same_wdata", wb_wdata, 32'h1);
    check("same_cnt", 32'(dut.u_ctr.cnt), 32'd0);
    set_mem(1'b0, 5'd0, 32'h0);
    set_lu(1'b0, 5'd0, 32'h0);
    tick();
    check("same_no_late_we", 32'(wb_we), 32'd0);
    check("same_no_late_wdata", wb_wdata, 32'd0);

    // Async reset in the middle of DRAIN
    set_mem(1'b1, 5'd3, 32'h33);
    set_lu(1'b1, 5'd7, 32'h77);
    for (int i = 0; i < 4; i++) tick();
    check("pre_rst_stallreq", 32'(stallreq), 32'd1);
    check("pre_rst_we", 32'(wb_we), 32'd1);
    #3;
    mem_we = 1'b0;
    rst    = 1'b1;
    #1;
    check("arst_stallreq", 32'(stallreq), 32'd0);
    check("arst_we", 32'(wb_we), 32'd0);
    check("arst_lu_ready", 32'(lu_ready), 32'd0);
    lu_valid = 1'b0;
    #3 rst = 1'b0;
    tick();
    check("post_rst_state", 32'(dut.u_ctr.state), 32'(WB_IDLE));
    check("post_rst_cnt", 32'(dut.u_ctr.cnt), 32'd0);
    check("post_rst_we", 32'(wb_we), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

- Write-back stage register and arbiter driving the single regfile write port (`we`/`waddr`/`wdata`).
- Merges two producers into that one port, with one cycle of latency:
  - the in-order pipeline result from the MEM stage;
  - the result of a long-latency unit (divider / multi-cycle load) via a valid/ready handshake.
- Sits between the MEM/long-latency units and the regfile.
- Raises a stall request to the pipeline controller when the long-latency result has been starved too long.

## Interface
Parameters:
- `DATA_W`, 32, data width (matches `RegBus`)
- `ADDR_W`, 5, register address width (matches `RegAddrBus`)
- `STARVE_MAX`, 4, cycles a valid long-latency result may be refused before `stallreq` asserts

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk` in 1: clock.
  - `rst` in 1: reset.
- Pipeline controls:
  - `stall_i` in 1: pipeline stalled at MEM; the MEM slot this cycle is a bubble.
  - `flush_i` in 1: pipeline flush; the MEM slot this cycle is discarded.
- MEM-stage result:
  - `mem_we` in 1: MEM-stage write enable.
  - `mem_waddr` in ADDR_W: MEM-stage destination register.
  - `mem_wdata` in DATA_W: MEM-stage result.
- Long-latency handshake:
  - `lu_valid` in 1: long-latency result valid.
  - `lu_waddr` in ADDR_W: its destination register.
  - `lu_wdata` in DATA_W: its data.
  - `lu_ready` out 1: long-latency result accepted this cycle (combinational).
- Regfile write port:
  - `wb_we` out 1: regfile write enable (registered).
  - `wb_waddr` out ADDR_W: regfile write address (registered).
  - `wb_wdata` out DATA_W: regfile write data (registered).
- `stallreq` out 1: stall request to the pipeline controller (combinational from state).

## Operation
- MEM slot is "live" when `mem_we=1`, `mem_waddr!=0`, `stall_i=0` and `flush_i=0`.
- Writes to `$0` are dropped at the input; they never reach `wb_we`.
- Per-cycle selection, first match wins:
  1. `flush_i=1`:
     - next `wb_we=0`, `wb_waddr=0`, `wb_wdata=0`;
     - `lu_ready=0`;
     - starve counter holds.
  2. MEM slot live and `lu_valid=1`:
     - MEM wins the port;
     - if `lu_waddr==mem_waddr`, the LU result is stale (the younger write wins): `lu_ready=1`, LU data discarded, counter cleared;
     - otherwise `lu_ready=0` and the counter increments.
  3. MEM slot live, `lu_valid=0`: MEM wins the port.
  4. MEM slot not live, `lu_valid=1`:
     - `lu_ready=1`, LU result takes the slot;
     - if `lu_waddr==0`, the result is accepted with next `wb_we=0`;
     - counter cleared.
  5. Otherwise: next `wb_we=0`, address and data 0.
- State machine with a saturating counter `cnt` (0..STARVE_MAX):
  - IDLE:
    - to WAIT on a refused `lu_valid`, with `cnt=1`.
  - WAIT:
    - increments on each refusal;
    - to DRAIN when `cnt` reaches STARVE_MAX;
    - to IDLE on accept or `lu_valid=0`.
  - DRAIN:
    - `stallreq=1`;
    - the controller answers with `stall_i=1`, which grants the LU via rule 4;
    - to IDLE on accept, `cnt=0`;
    - if `lu_valid` drops, to IDLE with `stallreq` deasserted.
- `lu_*` must be held stable while `lu_valid=1` and `lu_ready=0`.

## Timing
- Latency: inputs sampled at posedge N; `wb_*` valid during cycle N+1.
- `lu_ready` is combinational from inputs and state. A transfer completes on the posedge where `lu_valid & lu_ready`.
- `stallreq` is a function of registered state only; there is no combinational path from `lu_valid`.
- Worst-case LU wait: STARVE_MAX refused cycles plus one DRAIN cycle.
- Reset (async, `rst=1`):
  - `wb_we=0`, `wb_waddr=0`, `wb_wdata=0`;
  - `stallreq=0`, `lu_ready=0`;
  - state IDLE, `cnt=0`.
- Reset asserted mid-DRAIN drops `stallreq` immediately. A pending LU result is not written; the producer re-presents it after reset.
- Flush during DRAIN: `stallreq` stays asserted and the counter holds.

## Structure
- Shared defines header, not this file:
  - `RegBus`, `RegAddrBus`, `RegNumLog2`;
  - `WriteEnable`, `ZeroWord`, `RstEnable`.
- Local state encodings: `WB_IDLE`, `WB_WAIT`, `WB_DRAIN`.
- One sub-module, `wb_starve_ctr`:
  - saturating counter plus 3-state FSM;
  - inputs: refuse/accept/valid;
  - outputs: `stallreq` and the state.
- Arbitration mux and output register stay in `wb_write_arbiter`.
- Target size: ~200 lines total.

## Test plan
- **MEM pass-through:**
  - Stimulus: `mem_we=1`, `mem_waddr=5`, `mem_wdata=32'h1234_5678`, `lu_valid=0`.
  - Required: next cycle `wb_we=1`, `wb_waddr=5`, `wb_wdata=32'h1234_5678`.
  - Repeat with `mem_waddr=0`: required `wb_we=0`.
- **LU fills bubble:**
  - Stimulus: `mem_we=0`, `lu_valid=1`, `lu_waddr=9`, `lu_wdata=32'hDEAD_BEEF`.
  - Required: `lu_ready=1` the same cycle; next cycle `wb_we=1`, `wb_waddr=9`, `wb_wdata=32'hDEAD_BEEF`.
- **Starvation:**
  - Stimulus: MEM slot live every cycle with `mem_waddr=3`; `lu_valid=1` with `lu_waddr=7`.
  - Required: `lu_ready=0` for 4 cycles, then `stallreq=1`.
  - Bench drives `stall_i=1`: required `lu_ready=1`, `wb_waddr=7` next cycle, and `stallreq=0` after the accept.
- **Same-address conflict:**
  - Stimulus: MEM `waddr=4`, data `32'h1`; `lu_valid=1`, `lu_waddr=4`, data `32'h2`.
  - Required: `lu_ready=1`; next cycle `wb_wdata=32'h1`; no later write of `32'h2`.
- **Flush:**
  - Stimulus: `flush_i=1` with MEM live and `lu_valid=1`.
  - Required: next cycle `wb_we=0`, `lu_ready=0`, counter unchanged.
- **Async reset:**
  - Stimulus: assert `rst` mid-DRAIN, away from a clock edge.
  - Required: `stallreq`, `wb_we` and `lu_ready` go to 0 immediately; after release, state is IDLE and `cnt=0`.
